sprite_store: RTL

Holds the sprite bitmap and position, and feeds the per-pixel sprite line stage directly upstream of it. Each cycle it supplies the current raw bitmap bit (`sprite_data`) and the visibility flag (`sprite_visible`). It advances its read pointer when the downstream stage asserts `sprite_shift`. New bitmaps and positions arrive via a valid/ready serial load port into a shadow buffer and a position-update strobe; both are committed only at `frame_start`, so there is no tearing.

---
 rtl/sprite_store.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sprite_store.sv
// Sprite bitmap/position store: double-buffered bitmap with serial loader,
// clamped position with deferred commit, and a shift-driven read pointer.
module sprite_store #(
   parameter int WIDTH    = 12,
   parameter int HEIGHT   = 10,
   parameter int COORD_W  = 7,
   parameter int H_BLOCKS = 80,
   parameter int V_BLOCKS = 60
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] block_x,
   input  logic [COORD_W-1:0] block_y,
   input  logic               sprite_shift,
   output logic               sprite_data,
   output logic               sprite_visible,
   input  logic               load_valid,
   input  logic               load_bit,
   output logic               load_ready,
   input  logic               pos_valid,
   input  logic [COORD_W-1:0] pos_x,
   input  logic [COORD_W-1:0] pos_y
);

   localparam int N     = WIDTH * HEIGHT;
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [PTR_W-1:0]   LAST  = PTR_W'(N - 1);
   localparam logic [COORD_W-1:0] MAX_X = COORD_W'(H_BLOCKS - WIDTH);
   localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(V_BLOCKS - HEIGHT);
   localparam logic [COORD_W:0]   W_EXT = (COORD_W + 1)'(WIDTH);
   localparam logic [COORD_W:0]   H_EXT = (COORD_W + 1)'(HEIGHT);

   typedef enum logic {
      S_FILL,
      S_PENDING
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               w_accept;
   logic               w_commit;

   logic [N-1:0]       r_active;
   logic [N-1:0]       r_shadow;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_load_ptr;

   logic [COORD_W-1:0] r_cur_x;
   logic [COORD_W-1:0] r_cur_y;
   logic [COORD_W-1:0] r_pend_x;
   logic [COORD_W-1:0] r_pend_y;
   logic               r_pos_dirty;

   logic [COORD_W-1:0] w_clamp_x;
   logic [COORD_W-1:0] w_clamp_y;
   logic [COORD_W:0]   w_bx;
   logic [COORD_W:0]   w_by;
   logic [COORD_W:0]   w_cx;
   logic [COORD_W:0]   w_cy;
   logic [COORD_W:0]   w_x_end;
   logic [COORD_W:0]   w_y_end;

   // ---------------- loader FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      load_ready   = 1'b0;
      case (r_state)
         S_FILL: begin
            load_ready = 1'b1;
            w_accept   = load_valid;
            if (load_valid && (r_load_ptr == LAST)) begin
               w_state_next = S_PENDING;
            end
         end
         S_PENDING: begin
            if (frame_start) begin
               w_commit     = 1'b1;
               w_state_next = S_FILL;
            end
         end
         default: w_state_next = S_FILL;
      endcase
   end

   // A coincident frame_start during the final accepted bit sees FILL, so the
   // copy waits for the next frame_start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow   <= '0;
         r_active   <= '0;
         r_load_ptr <= '0;
      end else begin
         if (w_accept) begin
            r_shadow[r_load_ptr] <= load_bit;
            r_load_ptr           <= (r_load_ptr == LAST) ? '0 : r_load_ptr + 1'b1;
         end
         if (w_commit) begin
            r_active <= r_shadow;
         end
      end
   end

   // ---------------- read pointer ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (frame_start) begin
         r_ptr <= '0;
      end else if (sprite_shift) begin
         r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
      end
   end

   assign sprite_data = r_active[r_ptr];

   // ---------------- position ----------------
   assign w_clamp_x = (pos_x > MAX_X) ? MAX_X : pos_x;
   assign w_clamp_y = (pos_y > MAX_Y) ? MAX_Y : pos_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_x     <= '0;
         r_cur_y     <= '0;
         r_pend_x    <= '0;
         r_pend_y    <= '0;
         r_pos_dirty <= 1'b0;
      end else if (frame_start) begin
         if (pos_valid) begin
            r_cur_x  <= w_clamp_x;
            r_cur_y  <= w_clamp_y;
            r_pend_x <= w_clamp_x;
            r_pend_y <= w_clamp_y;
         end else if (r_pos_dirty) begin
            r_cur_x <= r_pend_x;
            r_cur_y <= r_pend_y;
         end
         r_pos_dirty <= 1'b0;
      end else if (pos_valid) begin
         r_pend_x    <= w_clamp_x;
         r_pend_y    <= w_clamp_y;
         r_pos_dirty <= 1'b1;
      end
   end

   // Extended by one bit so cur+WIDTH cannot wrap.
   assign w_bx    = {1'b0, block_x};
   assign w_by    = {1'b0, block_y};
   assign w_cx    = {1'b0, r_cur_x};
   assign w_cy    = {1'b0, r_cur_y};
   assign w_x_end = w_cx + W_EXT;
   assign w_y_end = w_cy + H_EXT;

   assign sprite_visible = (w_bx >= w_cx) && (w_bx < w_x_end) &&
                           (w_by >= w_cy) && (w_by < w_y_end);

endmodule
